uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Byte FIFO feeding a UART transmitter: each queued byte is presented on tx_data/tx_en until
// tx_done (or a timeout), then a fixed idle gap is enforced before the next byte.
module uart_tx_ctrl #(
  parameter int          DEPTH   = 8,
  parameter int          GAP_CYC = 2,
  parameter logic [15:0] TO_CYC  = 16'd50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [7:0]               push_data,
  output logic                     push_ready,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     ovf,
  output logic                     to_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t          state_reg;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            tx_en_reg;
  logic [7:0]      tx_data_reg;
  logic            ovf_reg;
  logic            to_err_reg;
  logic [7:0]      gap_cnt_reg;
  logic [15:0]     to_cnt_reg;

  logic full;
  logic push_acc;
  logic pop;
  logic ovf_set;
  logic to_hit;

  assign full     = (count_reg == CW'(DEPTH));
  assign push_acc = push_valid && !full;
  assign pop      = (state_reg == LOAD);
  // A push while full is lost even if the FSM pops in the same cycle.
  assign ovf_set  = push_valid && full;
  assign to_hit   = (state_reg == SEND) && !tx_done && ((to_cnt_reg + 16'd1) == TO_CYC);

  always_comb begin
    count_next = count_reg;
    case ({push_acc, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it maps onto RAM; the read is registered into tx_data.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      tx_en_reg   <= 1'b0;
      tx_data_reg <= 8'h00;
      ovf_reg     <= 1'b0;
      to_err_reg  <= 1'b0;
      gap_cnt_reg <= '0;
      to_cnt_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end

      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (clr_err) begin
        ovf_reg <= 1'b0;
      end

      if (to_hit) begin
        to_err_reg <= 1'b1;
      end else if (clr_err) begin
        to_err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          tx_data_reg <= mem[rd_ptr_reg];
          rd_ptr_reg  <= rd_ptr_reg + AW'(1);
          to_cnt_reg  <= '0;
          tx_en_reg   <= 1'b1;
          state_reg   <= SEND;
        end
        SEND: begin
          if (tx_done) begin
            tx_en_reg   <= 1'b0;
            gap_cnt_reg <= 8'(GAP_CYC);
            state_reg   <= GAP;
          end else begin
            // Counter stops at TO_CYC because the state leaves SEND on that same edge.
            to_cnt_reg <= to_cnt_reg + 16'd1;
            if (to_hit) begin
              tx_en_reg   <= 1'b0;
              gap_cnt_reg <= 8'(GAP_CYC);
              state_reg   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
          if (gap_cnt_reg <= 8'd1) begin
            state_reg <= (count_reg != '0) ? LOAD : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_en_reg <= 1'b0;
        end
      endcase
    end
  end

  assign push_ready = !full;
  assign tx_en      = tx_en_reg;
  assign tx_data    = tx_data_reg;
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign ovf        = ovf_reg;
  assign to_err     = to_err_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with DEPTH=8, GAP_CYC=2, TO_CYC=10; expected values are
// hand-derived edge by edge from the block's cycle behaviour.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       clr_err;
  logic [3:0] fifo_count;
  logic       busy;
  logic       ovf;
  logic       to_err;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_ctrl #(
    .DEPTH   (8),
    .GAP_CYC (2),
    .TO_CYC  (16'd10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .clr_err    (clr_err),
    .fifo_count (fifo_count),
    .busy       (busy),
    .ovf        (ovf),
    .to_err     (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are then examined 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for tx_en, check the byte, then measure how long tx_en stays high.
  task automatic expect_byte(input logic [7:0] exp_byte, input int exp_len);
    int w;
    int n;
    w = 0;
    while (!tx_en && w < 30) begin
      tick();
      w++;
    end
    check("tx_en_rise", {31'd0, tx_en}, 32'd1);
    check("tx_data_order", {24'd0, tx_data}, {24'd0, exp_byte});
    n = 0;
    while (tx_en && n < 30) begin
      n++;
      tick();
    end
    check("tx_en_len", n, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    logic seen;

    rst        = 1'b1;
    push_valid = 1'b0;
    push_data  = 8'h00;
    tx_done    = 1'b0;
    clr_err    = 1'b0;
    #1;
    check("rst_tx_en",      {31'd0, tx_en},      32'd0);
    check("rst_tx_data",    {24'd0, tx_data},    32'h00);
    check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
    check("rst_push_ready", {31'd0, push_ready}, 32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_ovf",        {31'd0, ovf},        32'd0);
    check("rst_to_err",     {31'd0, to_err},     32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single byte, tx_done after 5 SEND cycles.
    push_valid = 1'b1;
    push_data  = 8'hA5;
    tick();
    push_valid = 1'b0;
    check("a_count_after_push", {28'd0, fifo_count}, 32'd1);
    check("a_tx_en_e0",         {31'd0, tx_en},      32'd0);
    tick();
    check("a_tx_en_e1", {31'd0, tx_en}, 32'd0);
    check("a_busy_load", {31'd0, busy}, 32'd1);
    tick();
    check("a_tx_en_e2",  {31'd0, tx_en},      32'd1);
    check("a_tx_data",   {24'd0, tx_data},    32'hA5);
    check("a_count_pop", {28'd0, fifo_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("a_tx_en_hold", {31'd0, tx_en}, 32'd1);
      tick();
    end
    tx_done = 1'b1;
    check("a_tx_en_before_done", {31'd0, tx_en}, 32'd1);
    tick();
    tx_done = 1'b0;
    check("a_tx_en_fall", {31'd0, tx_en}, 32'd0);
    check("a_busy_gap1",  {31'd0, busy},  32'd1);
    check("a_tx_data_kept", {24'd0, tx_data}, 32'hA5);
    tick();
    check("a_busy_gap2", {31'd0, busy}, 32'd1);
    tick();
    check("a_busy_idle", {31'd0, busy},   32'd0);
    check("a_to_err",    {31'd0, to_err}, 32'd0);

    // Fill the FIFO while a byte is stuck in SEND, then overflow it.
    push_valid = 1'b1;
    push_data  = 8'hEE;
    tick();
    push_valid = 1'b0;
    wait_cnt = 0;
    while (!tx_en && wait_cnt < 10) begin
      tick();
      wait_cnt++;
    end
    check("b_first_send", {31'd0, tx_en}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      push_valid = 1'b1;
      push_data  = 8'(k);
      tick();
    end
    push_valid = 1'b0;
    check("b_full_ready", {31'd0, push_ready}, 32'd0);
    check("b_full_count", {28'd0, fifo_count}, 32'd8);
    check("b_still_send", {31'd0, tx_en},      32'd1);
    check("b_ovf_before", {31'd0, ovf},        32'd0);
    push_valid = 1'b1;
    push_data  = 8'h09;
    tick();
    check("b_ovf_set",      {31'd0, ovf},        32'd1);
    check("b_count_ovf",    {28'd0, fifo_count}, 32'd8);
    check("b_to_err_early", {31'd0, to_err},     32'd0);
    // Keep pushing while full; clr_err in the same cycle as set conditions must lose.
    push_data = 8'h0A;
    clr_err   = 1'b1;
    tick();
    clr_err = 1'b0;
    check("b_to_err_set",  {31'd0, to_err},     32'd1);
    check("b_ovf_set_wins", {31'd0, ovf},       32'd1);
    check("b_tx_en_gap",   {31'd0, tx_en},      32'd0);
    check("b_count_gap",   {28'd0, fifo_count}, 32'd8);
    tick();
    tick();
    check("b_count_at_load", {28'd0, fifo_count}, 32'd8);
    tick();
    push_valid = 1'b0;
    check("b_count_pop_drop", {28'd0, fifo_count}, 32'd7);
    check("b_ovf_kept",       {31'd0, ovf},        32'd1);
    for (int k = 1; k <= 8; k++) begin
      expect_byte(8'(k), 10);
    end
    tick();
    tick();
    tick();
    check("b_drained_busy",  {31'd0, busy},       32'd0);
    check("b_drained_count", {28'd0, fifo_count}, 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("b_clr_to_err", {31'd0, to_err}, 32'd0);
    check("b_clr_ovf",    {31'd0, ovf},    32'd0);

    // Asynchronous reset while sending with 3 bytes queued.
    for (int k = 0; k < 4; k++) begin
      push_valid = 1'b1;
      push_data  = 8'hB0 + 8'(k);
      tick();
    end
    push_valid = 1'b0;
    check("c_sending",    {31'd0, tx_en},      32'd1);
    check("c_queued",     {28'd0, fifo_count}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("c_rst_tx_en", {31'd0, tx_en},      32'd0);
    check("c_rst_count", {28'd0, fifo_count}, 32'd0);
    check("c_rst_busy",  {31'd0, busy},       32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | tx_en;
    end
    check("c_no_tx_after_rst", {31'd0, seen}, 32'd0);
    push_valid = 1'b1;
    push_data  = 8'h5A;
    tick();
    push_valid = 1'b0;
    check("c_push_after_rst", {28'd0, fifo_count}, 32'd1);
    tx_done = 1'b1;
    expect_byte(8'h5A, 1);
    tx_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
